instr_mem: RTL and testbench

INSTR_MEM -- requirements
Module: instr_mem

---
 rtl/instr_mem.sv | 67 ++++++
 tb/tb_instr_mem.sv | 121 ++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
// Read-only instruction memory: 32 fixed 16-bit words, byte-addressed, registered output.
// Define INSTR_MEM_WRAP_EN to wrap out-of-range pointers modulo 64 bytes instead of returning NOP.
module instr_mem #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pointer,
   output logic [DATA_W-1:0] instr_out
);

   logic [4:0]        word_idx;
   logic [DATA_W-1:0] rom_word;
   logic [DATA_W-1:0] fetch_word;
   logic              out_of_range;

   // The low bit selects a byte within a 16-bit word, so it never affects the fetch.
   assign word_idx = pointer[5:1];

   generate
      if (ADDR_W > 6) begin : g_range
         assign out_of_range = |pointer[ADDR_W-1:6];
      end else begin : g_no_range
         assign out_of_range = 1'b0;
      end
   endgenerate

   always_comb begin
      rom_word = '0;
      if (int'(word_idx) < DEPTH) begin
         case (word_idx)
            5'd0:    rom_word = DATA_W'(16'h1123);
            5'd1:    rom_word = DATA_W'(16'h2245);
            5'd2:    rom_word = DATA_W'(16'h3367);
            5'd3:    rom_word = DATA_W'(16'h4489);
            5'd4:    rom_word = DATA_W'(16'h55AB);
            5'd5:    rom_word = DATA_W'(16'h66CD);
            5'd6:    rom_word = DATA_W'(16'h77EF);
            5'd7:    rom_word = DATA_W'(16'h8801);
            5'd31:   rom_word = DATA_W'(16'hF000);
            default: rom_word = '0;
         endcase
      end
   end

`ifdef INSTR_MEM_WRAP_EN
   // Upper pointer bits are discarded entirely when wrapping.
   logic unused_ptr_bits;
   assign unused_ptr_bits = out_of_range ^ pointer[0];
   assign fetch_word      = rom_word;
`else
   logic unused_ptr_bit;
   assign unused_ptr_bit = pointer[0];
   assign fetch_word     = out_of_range ? '0 : rom_word;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_out <= '0;
      end else begin
         instr_out <= fetch_word;
      end
   end

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: vector table plus hand-written mid-cycle sequences.
module tb_instr_mem;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int NVEC   = 22;

`ifdef INSTR_MEM_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   typedef struct {
      logic              rst;
      logic [ADDR_W-1:0] ptr;
      logic [DATA_W-1:0] exp;
   } vec_t;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] pointer;
   logic [DATA_W-1:0] instr_out;

   int total;
   int bad;
   vec_t vecs [NVEC];

   instr_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .pointer   (pointer),
      .instr_out (instr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      pointer = '0;

      vecs[0]  = '{1'b1, 16'd0,     16'h0000};
      vecs[1]  = '{1'b0, 16'd0,     16'h1123};
      vecs[2]  = '{1'b0, 16'd2,     16'h2245};
      vecs[3]  = '{1'b0, 16'd4,     16'h3367};
      vecs[4]  = '{1'b0, 16'd6,     16'h4489};
      vecs[5]  = '{1'b0, 16'd8,     16'h55AB};
      vecs[6]  = '{1'b0, 16'd10,    16'h66CD};
      vecs[7]  = '{1'b0, 16'd12,    16'h77EF};
      vecs[8]  = '{1'b0, 16'd14,    16'h8801};
      vecs[9]  = '{1'b0, 16'd16,    16'h0000};
      vecs[10] = '{1'b0, 16'd60,    16'h0000};
      vecs[11] = '{1'b0, 16'd62,    16'hF000};
      vecs[12] = '{1'b0, 16'd7,     16'h4489};
      vecs[13] = '{1'b0, 16'd5,     16'h3367};
      vecs[14] = '{1'b0, 16'd1,     16'h1123};
      vecs[15] = '{1'b0, 16'd63,    16'hF000};
      vecs[16] = '{1'b0, 16'd64,    WRAP ? 16'h1123 : 16'h0000};
      vecs[17] = '{1'b0, 16'd66,    WRAP ? 16'h2245 : 16'h0000};
      vecs[18] = '{1'b0, 16'hFFFE,  WRAP ? 16'hF000 : 16'h0000};
      vecs[19] = '{1'b1, 16'd10,    16'h0000};
      vecs[20] = '{1'b0, 16'd10,    16'h66CD};
      vecs[21] = '{1'b1, 16'd62,    16'h0000};

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rst     = vecs[i].rst;
         pointer = vecs[i].ptr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d ptr=%0d rst=%0b", i, vecs[i].ptr, vecs[i].rst),
               instr_out, vecs[i].exp);
      end

      // Pointer changes after the edge must not disturb the registered word.
      @(negedge clk);
      rst     = 1'b0;
      pointer = 16'd0;
      @(posedge clk);
      #1;
      check("midcyc_base", instr_out, 16'h1123);
      @(negedge clk);
      pointer = 16'd14;
      #2;
      check("midcyc_hold", instr_out, 16'h1123);
      @(posedge clk);
      #1;
      check("midcyc_new", instr_out, 16'h8801);

      // Reset raised between edges has no effect until the next edge.
      @(negedge clk);
      pointer = 16'd4;
      rst     = 1'b1;
      #2;
      check("rst_no_async", instr_out, 16'h8801);
      @(posedge clk);
      #1;
      check("rst_sync", instr_out, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_release_fetch", instr_out, 16'h3367);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
